// File: rtl/nes_cpu_pkg.sv
// Shared types and constants for the CPU memory subsystem: address width,
// OAM DMA states and the registered access-stage record.
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;
  localparam int OAM_SIZE = 256;
  localparam logic [15:0] DMA_TRIGGER_DEFAULT = 16'h4014;
  localparam logic [7:0] OAM_LAST = 8'(OAM_SIZE - 1);

  typedef enum logic [1:0] {DMA_IDLE, DMA_READ, DMA_WRITE} dma_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     is_data;
    logic                     we;
    logic                     trigger;
    logic [MEM_ADDR_SIZE-1:0] addr;
    logic [7:0]               wdata;
  } access_t;

  // Page-relative DMA address; the index never carries into the page byte.
  function automatic logic [MEM_ADDR_SIZE-1:0] page_addr(input logic [7:0] page,
                                                         input logic [7:0] idx);
    return MEM_ADDR_SIZE'({page, idx});
  endfunction

endpackage

// File: rtl/mem_arbiter_t_if.sv
// Bundle of the fetch port, data port, memory port and OAM output of the
// memory arbiter; slave is the arbiter side, master the CPU/memory side.
interface mem_arbiter_t_if;
  import nes_cpu_pkg::*;

  logic                     fetch_req_i;
  logic [MEM_ADDR_SIZE-1:0] fetch_addr_i;
  logic                     fetch_gnt_o;
  logic                     fetch_rvalid_o;
  logic [23:0]              fetch_rdata_o;

  logic                     data_req_i;
  logic                     data_we_i;
  logic [MEM_ADDR_SIZE-1:0] data_addr_i;
  logic [7:0]               data_wdata_i;
  logic                     data_gnt_o;
  logic                     data_rvalid_o;
  logic [7:0]               data_rdata_o;

  logic [MEM_ADDR_SIZE-1:0] mem_addr_o;
  logic [7:0]               mem_wdata_o;
  logic                     mem_we_o;
  logic [23:0]              mem_rdata_i;

  logic                     oam_we_o;
  logic [7:0]               oam_addr_o;
  logic [7:0]               oam_data_o;
  logic                     dma_busy_o;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o,
    input  mem_rdata_i,
    output oam_we_o, oam_addr_o, oam_data_o, dma_busy_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    output data_req_i, data_we_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o,
    output mem_rdata_i,
    input  oam_we_o, oam_addr_o, oam_data_o, dma_busy_o
  );

endinterface

// File: rtl/mem_arbiter_t_oam_dma.sv
// OAM DMA engine: copies one 256-byte memory page to the OAM port,
// alternating a memory read cycle with an OAM write cycle.
//   state     | meaning
//   DMA_IDLE  | waiting for a trigger write
//   DMA_READ  | drives {page,idx} to memory, captures the byte
//   DMA_WRITE | strobes OAM[idx] with the captured byte
module oam_dma_t
  import nes_cpu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start,
  input  logic [7:0]               start_page,
  input  logic [7:0]               rdata,
  output logic                     busy,
  output logic                     rd_en,
  output logic [MEM_ADDR_SIZE-1:0] rd_addr,
  output logic                     oam_we,
  output logic [7:0]               oam_addr,
  output logic [7:0]               oam_data
);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] byte_q, byte_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DMA_IDLE;
      idx_q   <= '0;
      page_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    byte_d  = byte_q;
    oam_we  = 1'b0;
    case (state_q)
      DMA_IDLE: begin
        if (start) begin
          state_d = DMA_READ;
          idx_d   = '0;
          page_d  = start_page;
        end
      end
      DMA_READ: begin
        byte_d  = rdata;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        oam_we = 1'b1;
        if (idx_q == OAM_LAST) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DMA_READ;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  assign busy     = (state_q != DMA_IDLE);
  assign rd_en    = (state_q == DMA_READ);
  assign rd_addr  = page_addr(page_q, idx_q);
  assign oam_addr = oam_we ? idx_q : '0;
  assign oam_data = oam_we ? byte_q : '0;

endmodule

// File: rtl/mem_arbiter_t.sv
// Shares one memory port between CPU fetch, CPU data and the OAM DMA engine;
// a one-entry access stage answers each grant on the following cycle.
module mem_arbiter_t
  import nes_cpu_pkg::*;
#(
  parameter logic [MEM_ADDR_SIZE-1:0] DMA_TRIGGER_ADDR = MEM_ADDR_SIZE'(DMA_TRIGGER_DEFAULT)
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_t_if.slave bus
);

  logic                     fetch_lost;
  logic                     fetch_gnt;
  logic                     data_gnt;
  logic                     dma_start;
  logic                     dma_busy;
  logic                     dma_rd;
  logic [MEM_ADDR_SIZE-1:0] dma_addr;
  access_t                  stage;

  // Data has priority except right after fetch lost, so contention alternates.
  always_comb begin
    fetch_gnt = !rst_i && !dma_busy && bus.fetch_req_i && (!bus.data_req_i || fetch_lost);
    data_gnt  = !rst_i && !dma_busy && bus.data_req_i && !(bus.fetch_req_i && fetch_lost);
    dma_start = data_gnt && bus.data_we_i && (bus.data_addr_i == DMA_TRIGGER_ADDR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_lost <= 1'b0;
      stage      <= '0;
    end else begin
      if (!dma_busy) fetch_lost <= bus.fetch_req_i && !fetch_gnt;
      stage.valid <= fetch_gnt || data_gnt;
      if (fetch_gnt || data_gnt) begin
        stage.is_data <= data_gnt;
        stage.we      <= data_gnt && bus.data_we_i;
        stage.trigger <= dma_start;
        stage.addr    <= data_gnt ? bus.data_addr_i : bus.fetch_addr_i;
        stage.wdata   <= bus.data_wdata_i;
      end
    end
  end

  oam_dma_t u_dma (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start      (dma_start),
    .start_page (bus.data_wdata_i),
    .rdata      (bus.mem_rdata_i[7:0]),
    .busy       (dma_busy),
    .rd_en      (dma_rd),
    .rd_addr    (dma_addr),
    .oam_we     (bus.oam_we_o),
    .oam_addr   (bus.oam_addr_o),
    .oam_data   (bus.oam_data_o)
  );

  assign bus.fetch_gnt_o    = fetch_gnt;
  assign bus.data_gnt_o     = data_gnt;
  assign bus.fetch_rvalid_o = stage.valid && !stage.is_data;
  assign bus.data_rvalid_o  = stage.valid && stage.is_data;
  assign bus.fetch_rdata_o  = bus.fetch_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.data_rdata_o   = bus.data_rvalid_o ? bus.mem_rdata_i[7:0] : '0;
  // The trigger write is acknowledged but never reaches memory.
  assign bus.mem_we_o       = stage.valid && stage.we && !stage.trigger;
  assign bus.mem_wdata_o    = stage.wdata;
  assign bus.mem_addr_o     = dma_rd ? dma_addr : stage.addr;
  assign bus.dma_busy_o     = dma_busy;

endmodule

// File: tb/tb_mem_arbiter_t.sv
// Directed bench for mem_arbiter_t: behavioural memory, response scoreboard
// and an OAM copy checker against a reference memory image.
module tb_mem_arbiter_t;
  import nes_cpu_pkg::*;

  logic clk;
  logic rst;
  mem_arbiter_t_if bus ();

  mem_arbiter_t dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h12;
      16'h0011: return 8'h34;
      16'h0012: return 8'h56;
      default:  return (a[7:0] * 8'd5) ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  // Physical memory: initial pattern overlaid by DUT writes.
  bit   [7:0]  wm [0:65535];
  bit          wv [0:65535];
  logic [15:0] a0, a1, a2;
  assign a0 = bus.mem_addr_o;
  assign a1 = a0 + 16'd1;
  assign a2 = a0 + 16'd2;
  assign bus.mem_rdata_i = {wv[a2] ? wm[a2] : pat(a2),
                            wv[a1] ? wm[a1] : pat(a1),
                            wv[a0] ? wm[a0] : pat(a0)};

  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      wm[bus.mem_addr_o] <= bus.mem_wdata_o;
      wv[bus.mem_addr_o] <= 1'b1;
    end
  end

  logic [7:0]  ref_mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  logic        f_pend, d_pend, we_pend;
  logic [23:0] fq [$];
  logic [8:0]  dq [$];
  logic        last_fg, last_dg, last_busy;
  logic [23:0] last_frd;
  logic [7:0]  last_drd;
  logic [7:0]  page_m;
  logic [7:0]  oam_i;
  int          oam_cnt, busy_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 32'({bus.fetch_gnt_o, bus.data_gnt_o, bus.fetch_rvalid_o,
                              bus.data_rvalid_o, bus.mem_we_o, bus.oam_we_o, bus.dma_busy_o}), 32'd0);
    check({tag, "_fetch_rdata"}, 32'(bus.fetch_rdata_o), 32'd0);
    check({tag, "_data_rdata"}, 32'(bus.data_rdata_o), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr_o), 32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata_o), 32'd0);
    check({tag, "_oam"}, 32'({bus.oam_addr_o, bus.oam_data_o}), 32'd0);
  endtask

  task automatic clear_sb();
    f_pend  = 1'b0;
    d_pend  = 1'b0;
    we_pend = 1'b0;
    fq.delete();
    dq.delete();
  endtask

  // One cycle: sample at negedge, score responses, record new grants.
  task automatic step();
    logic [23:0] ef;
    logic [8:0]  ed;
    logic [15:0] fa;
    @(negedge clk);
    check("fetch_rvalid", 32'(bus.fetch_rvalid_o), 32'(f_pend));
    check("data_rvalid", 32'(bus.data_rvalid_o), 32'(d_pend));
    check("mem_we", 32'(bus.mem_we_o), 32'(we_pend));
    if (bus.fetch_rvalid_o) begin
      if (fq.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
      else begin
        ef = fq.pop_front();
        check("fetch_rdata", 32'(bus.fetch_rdata_o), 32'(ef));
      end
    end
    if (bus.data_rvalid_o) begin
      if (dq.size() == 0) check("data_unexpected", 32'd1, 32'd0);
      else begin
        ed = dq.pop_front();
        if (ed[8]) check("data_rdata", 32'(bus.data_rdata_o), 32'(ed[7:0]));
      end
    end
    if (bus.oam_we_o) begin
      check("oam_addr", 32'(bus.oam_addr_o), 32'(oam_i));
      check("oam_data", 32'(bus.oam_data_o), 32'(ref_mem[{page_m, oam_i}]));
      oam_i = oam_i + 8'd1;
      oam_cnt++;
    end
    if (bus.dma_busy_o) busy_cnt++;
    last_fg   = bus.fetch_gnt_o;
    last_dg   = bus.data_gnt_o;
    last_busy = bus.dma_busy_o;
    last_frd  = bus.fetch_rdata_o;
    last_drd  = bus.data_rdata_o;
    f_pend  = bus.fetch_gnt_o;
    d_pend  = bus.data_gnt_o;
    we_pend = 1'b0;
    if (bus.fetch_gnt_o) begin
      fa = bus.fetch_addr_i;
      fq.push_back({ref_mem[fa + 16'd2], ref_mem[fa + 16'd1], ref_mem[fa]});
    end
    if (bus.data_gnt_o) begin
      if (bus.data_we_i) begin
        if (bus.data_addr_i == 16'h4014) begin
          page_m  = bus.data_wdata_i;
          oam_i   = 8'd0;
          oam_cnt = 0;
        end else begin
          ref_mem[bus.data_addr_i] = bus.data_wdata_i;
          we_pend = 1'b1;
        end
        dq.push_back(9'h000);
      end else begin
        dq.push_back({1'b1, ref_mem[bus.data_addr_i]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  seq [4];
    logic [7:0]  drd_read;
    int          gnt_at;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
    clear_sb();
    oam_i = '0; oam_cnt = 0; busy_cnt = 0; page_m = '0;
    rst = 1'b1;
    bus.fetch_req_i = 1'b0; bus.fetch_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0;
    bus.data_addr_i = '0; bus.data_wdata_i = '0;
    #2;
    check_outputs_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    step();

    // Single fetch
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 16'h0010;
    step();
    check("single_fetch_gnt", 32'({last_fg, last_dg}), 32'b10);
    bus.fetch_req_i = 1'b0;
    step();
    check("single_fetch_rdata", 32'(last_frd), 32'h563412);

    // Reset with an access in flight
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 16'h0040;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 16'h0030;
    step();
    check("pre_reset_gnt", 32'({last_fg, last_dg}), 32'b01);
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    clear_sb();
    bus.fetch_req_i = 1'b0; bus.data_req_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();

    // Contention: data write, fetch, data read, fetch
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 16'h0020;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1;
    bus.data_addr_i = 16'h0200; bus.data_wdata_i = 8'hAB;
    step(); seq[0] = {last_fg, last_dg};
    bus.data_we_i = 1'b0;
    step(); seq[1] = {last_fg, last_dg};
    step(); seq[2] = {last_fg, last_dg};
    step(); seq[3] = {last_fg, last_dg};
    drd_read = last_drd;
    bus.fetch_req_i = 1'b0; bus.data_req_i = 1'b0;
    step();
    check("contention_0", 32'(seq[0]), 32'b01);
    check("contention_1", 32'(seq[1]), 32'b10);
    check("contention_2", 32'(seq[2]), 32'b01);
    check("contention_3", 32'(seq[3]), 32'b10);
    check("write_then_read", 32'(drd_read), 32'hAB);

    // DMA of page 0x02 with fetch held throughout
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 16'h0020;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1;
    bus.data_addr_i = 16'h4014; bus.data_wdata_i = 8'h02;
    busy_cnt = 0;
    step();
    check("trigger_gnt", 32'({last_fg, last_dg}), 32'b01);
    bus.data_req_i = 1'b0;
    gnt_at = 0;
    for (int k = 1; k <= 600; k++) begin
      step();
      if (last_fg) begin
        gnt_at = k;
        break;
      end
    end
    check("stall_release_cycle", 32'(gnt_at), 32'd513);
    check("dma_busy_cycles", 32'(busy_cnt), 32'd512);
    check("dma_oam_writes", 32'(oam_cnt), 32'd256);
    check("dma_busy_end", 32'(last_busy), 32'd0);
    check("trigger_not_written", 32'(wv[16'h4014]), 32'd0);
    bus.fetch_req_i = 1'b0;
    step();

    // Reset in the middle of a DMA, then a fresh DMA of page 0x03
    bus.data_req_i = 1'b1; bus.data_wdata_i = 8'h02;
    step();
    bus.data_req_i = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (oam_cnt == 100) break;
    end
    check("mid_dma_reached", 32'(oam_cnt), 32'd100);
    #2 rst = 1'b1;
    #1 check("mid_dma_busy", 32'({bus.dma_busy_o, bus.oam_we_o}), 32'd0);
    clear_sb();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) step();
    check("after_reset_idle", 32'({last_busy, 8'(oam_cnt)}), 32'd100);
    bus.data_req_i = 1'b1; bus.data_wdata_i = 8'h03;
    step();
    check("retrigger_gnt", 32'(last_dg), 32'd1);
    bus.data_req_i = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (!last_busy && busy_cnt > 0) break;
    end
    check("restart_oam_writes", 32'(oam_cnt), 32'd256);
    check("restart_busy_cycles", 32'(busy_cnt), 32'd512);
    check("scoreboard_drained", 32'(fq.size() + dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
